// File: rtl/mips_muldiv_unit_if.sv
// Handshake and data bus between the pipeline and the multiply/divide unit.
// The pipeline drives requests and direct HI/LO writes; the unit returns status and HI/LO.
interface mips_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  mthi;
  logic                  mtlo;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  div_by_zero;

  modport master (
    output start, op, A, B, mthi, mtlo, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, A, B, mthi, mtlo, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with a FIX cycle that applies signs before HI/LO are committed.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  mips_muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_upper;
  logic [W-1:0]    r_lower;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_negA;
  logic            r_negB;
  logic            r_bzero;
  logic            r_busy;
  logic            r_done;
  logic            r_dbz;
  logic [CW-1:0]   r_count;

  logic            w_signed;
  logic [W-1:0]    w_magA;
  logic [W-1:0]    w_magB;
  logic [W:0]      w_mulSum;
  logic [W:0]      w_divShift;
  logic [W:0]      w_divDiff;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_quo;
  logic [W-1:0]    w_rem;
  logic [W-1:0]    w_resHi;
  logic [W-1:0]    w_resLo;

  // op[0] marks the signed variants (MULT, DIV); the datapath only ever sees magnitudes.
  always_comb begin
    w_signed   = bus.op[0];
    w_magA     = (w_signed && bus.A[W-1]) ? -bus.A : bus.A;
    w_magB     = (w_signed && bus.B[W-1]) ? -bus.B : bus.B;
    w_mulSum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_mcand} : '0);
    w_divShift = {r_upper, r_lower[W-1]};
    w_divDiff  = w_divShift - {1'b0, r_mcand};

    w_prod = {r_upper, r_lower};
    if (r_op == OP_MULT && (r_negA ^ r_negB)) begin
      w_prod = -{r_upper, r_lower};
    end

    w_quo = r_lower;
    w_rem = r_upper;
    if (r_op == OP_DIV) begin
      if (r_negA ^ r_negB) w_quo = -r_lower;
      if (r_negA)          w_rem = -r_upper;
    end

    w_resHi = w_prod[2*W-1:W];
    w_resLo = w_prod[W-1:0];
    if (r_op[1]) begin
      w_resHi = r_bzero ? r_a : w_rem;
      w_resLo = r_bzero ? '1  : w_quo;
    end
  end

  // Multiply keeps the multiplier in r_lower and shifts the product in from the top;
  // divide shifts the dividend out of r_lower while quotient bits fill in from below.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_mcand <= '0;
      r_upper <= '0;
      r_lower <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_negA  <= 1'b0;
      r_negB  <= 1'b0;
      r_bzero <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_count <= '0;
            r_op    <= bus.op;
            r_a     <= bus.A;
            r_negA  <= w_signed && bus.A[W-1];
            r_negB  <= w_signed && bus.B[W-1];
            r_bzero <= (bus.B == '0);
            r_upper <= '0;
            r_lower <= bus.op[1] ? w_magA : w_magB;
            r_mcand <= bus.op[1] ? w_magB : w_magA;
          end else begin
            r_state <= IDLE;
            if (bus.mthi) r_hi <= bus.wdata;
            if (bus.mtlo) r_lo <= bus.wdata;
          end
        end
        RUN: begin
          if (r_op[1]) begin
            if (!w_divDiff[W]) begin
              r_upper <= w_divDiff[W-1:0];
              r_lower <= {r_lower[W-2:0], 1'b1};
            end else begin
              r_upper <= w_divShift[W-1:0];
              r_lower <= {r_lower[W-2:0], 1'b0};
            end
          end else begin
            r_upper <= w_mulSum[W:1];
            r_lower <= {w_mulSum[0], r_lower[W-1:1]};
          end
          r_count <= r_count + CW'(1);
          if (r_count == CW'(W - 1)) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_resHi;
          r_lo    <= w_resLo;
          r_dbz   <= r_op[1] && r_bzero;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_count <= '0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: an arithmetic reference model is compared every cycle,
// and literal expectations at key cycles pin both the model and the DUT.
module tb_mips_muldiv_unit;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  int   doneCount;
  bit   modelValid;

  // Reference model state: cycles since accept (0 = not running), committed and pending results.
  int          mCnt;
  logic [31:0] mHi, mLo, pHi, pLo;
  logic        mDbz, pDbz;

  mips_muldiv_unit_if #(.DATA_WIDTH(W)) bus ();

  mips_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic hiW, input logic loW,
                               input logic [31:0] wd);
    bus.start = st;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    bus.mthi  = hiW;
    bus.mtlo  = loW;
    bus.wdata = wd;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic void computeResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                        output logic [31:0] rHi, output logic [31:0] rLo, output logic rDbz);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    rDbz = 1'b0;
    rHi  = '0;
    rLo  = '0;
    case (op)
      2'b00: begin
        p = {32'h0, a} * {32'h0, b};
        rHi = p[63:32];
        rLo = p[31:0];
      end
      2'b01: begin
        p = sa * sb;
        rHi = p[63:32];
        rLo = p[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          rDbz = 1'b1;
          rLo  = 32'hFFFF_FFFF;
          rHi  = a;
        end else if (op == 2'b10) begin
          rLo = a / b;
          rHi = a % b;
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          rLo = q[31:0];
          rHi = r[31:0];
        end
      end
    endcase
  endfunction

  // Model advances on the same edge as the DUT using the inputs held since the previous edge.
  always @(posedge clk) begin
    if (!reset) begin
      mCnt = 0; mHi = '0; mLo = '0; mDbz = 1'b0;
      modelValid = 1'b1;
    end else if (mCnt == 0 || mCnt == W + 2) begin
      if (bus.start) begin
        computeResult(bus.op, bus.A, bus.B, pHi, pLo, pDbz);
        mDbz = 1'b0;
        mCnt = 1;
      end else begin
        mCnt = 0;
        if (bus.mthi) mHi = bus.wdata;
        if (bus.mtlo) mLo = bus.wdata;
      end
    end else begin
      mCnt++;
      if (mCnt == W + 2) begin
        mHi = pHi; mLo = pLo; mDbz = pDbz;
      end
    end
  end

  // Every cycle once the model is reset, all outputs must match it.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("busy", {31'h0, bus.busy}, {31'h0, (mCnt >= 1 && mCnt <= W + 1)});
      checkOutput("done", {31'h0, bus.done}, {31'h0, (mCnt == W + 2)});
      checkOutput("hi", bus.hi, mHi);
      checkOutput("lo", bus.lo, mLo);
      checkOutput("div_by_zero", {31'h0, bus.div_by_zero}, {31'h0, mDbz});
      if (bus.done) doneCount++;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[6];
  int   doneBefore;

  initial begin
    checkCount = 0; errorCount = 0; doneCount = 0; modelValid = 1'b0;
    reset = 1'b0;
    clearInputs();
    stepCycles(2);
    checkOutput("reset_hi", bus.hi, 32'h0);
    checkOutput("reset_lo", bus.lo, 32'h0);
    checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("reset_done", {31'h0, bus.done}, 32'h0);

    // MULTU max*max accepted on the first edge out of reset; busy-time start/mthi ignored.
    reset = 1'b1;
    applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    stepCycles(1);
    checkOutput("multu_busy_c1", {31'h0, bus.busy}, 32'h1);
    applyStimulus(1'b0, 2'b01, 32'h5, 32'h9, 1'b0, 1'b0, 32'h0);
    stepCycles(4);
    applyStimulus(1'b1, 2'b01, 32'h7, 32'h7, 1'b1, 1'b0, 32'hDEAD);
    stepCycles(1);
    clearInputs();
    stepCycles(27);
    checkOutput("multu_busy_c33", {31'h0, bus.busy}, 32'h1);
    checkOutput("multu_done_c33", {31'h0, bus.done}, 32'h0);
    stepCycles(1);
    checkOutput("multu_done_c34", {31'h0, bus.done}, 32'h1);
    checkOutput("multu_busy_c34", {31'h0, bus.busy}, 32'h0);
    checkOutput("multu_hi", bus.hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", bus.lo, 32'h0000_0001);
    stepCycles(1);
    checkOutput("done_single_pulse", {31'h0, bus.done}, 32'h0);

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234);
    stepCycles(1);
    clearInputs();
    checkOutput("mtlo_lo", bus.lo, 32'h0000_1234);
    checkOutput("mtlo_hi_kept", bus.hi, 32'hFFFF_FFFE);

    // MULT -3*7, then DIV -7/2 started in its DONE cycle (back-to-back).
    applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b0, 32'h0);
    stepCycles(1);
    clearInputs();
    stepCycles(33);
    checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFF_FFEB);
    applyStimulus(1'b1, 2'b11, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, 32'h0);
    stepCycles(1);
    clearInputs();
    stepCycles(33);
    checkOutput("b2b_done_c68", {31'h0, bus.done}, 32'h1);
    checkOutput("div_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("div_dbz", {31'h0, bus.div_by_zero}, 32'h0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'hABCD);
    stepCycles(1);
    clearInputs();
    checkOutput("mthi_after_done_hi", bus.hi, 32'h0000_ABCD);
    checkOutput("mthi_after_done_lo", bus.lo, 32'hFFFF_FFFD);

    // DIVU by zero, then MULTU 2*3 clears the flag at acceptance.
    applyStimulus(1'b1, 2'b10, 32'd100, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycles(1);
    clearInputs();
    stepCycles(33);
    checkOutput("dbz_lo", bus.lo, 32'hFFFF_FFFF);
    checkOutput("dbz_hi", bus.hi, 32'h0000_0064);
    checkOutput("dbz_flag", {31'h0, bus.div_by_zero}, 32'h1);
    applyStimulus(1'b1, 2'b00, 32'h2, 32'h3, 1'b0, 1'b0, 32'h0);
    stepCycles(1);
    clearInputs();
    checkOutput("dbz_cleared", {31'h0, bus.div_by_zero}, 32'h0);
    stepCycles(33);
    checkOutput("mul23_lo", bus.lo, 32'h6);
    checkOutput("mul23_hi", bus.hi, 32'h0);
    stepCycles(1);

    // Signed overflow divide with mthi/mtlo in the start cycle (writes ignored).
    applyStimulus(1'b1, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h5555);
    stepCycles(1);
    clearInputs();
    stepCycles(33);
    checkOutput("ovf_lo", bus.lo, 32'h8000_0000);
    checkOutput("ovf_hi", bus.hi, 32'h0);
    stepCycles(1);

    vecs[0] = '{2'b10, 32'hFFFF_FFFF, 32'h7};
    vecs[1] = '{2'b11, 32'h7, 32'hFFFF_FFFE};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = '{2'b11, 32'h8000_0000, 32'h3};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{2'b01, 32'h1234_5678, 32'hFFFF_0001};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 32'h0);
      stepCycles(1);
      clearInputs();
      stepCycles(34);
    end

    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hCAFE);
    stepCycles(1);
    clearInputs();
    checkOutput("mthilo_hi", bus.hi, 32'h0000_CAFE);
    checkOutput("mthilo_lo", bus.lo, 32'h0000_CAFE);

    // Reset at cycle 10 of a MULT aborts it with no later done pulse.
    applyStimulus(1'b1, 2'b01, 32'h0001_2345, 32'hFFFF_FFFB, 1'b0, 1'b0, 32'h0);
    stepCycles(1);
    clearInputs();
    stepCycles(9);
    reset = 1'b0;
    stepCycles(1);
    reset = 1'b1;
    checkOutput("abort_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("abort_hi", bus.hi, 32'h0);
    checkOutput("abort_lo", bus.lo, 32'h0);
    doneBefore = doneCount;
    stepCycles(40);
    checkOutput("abort_no_done", doneCount, doneBefore);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand width and HI/LO register width; legal values are 4 or more.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be input, 1 bit: synchronous, active-low reset.
REQ-004 Port start SHALL be input, 1 bit: request a new operation; sampled only in IDLE or DONE.
REQ-005 Port op SHALL be input, 2 bits, with this encoding: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port A SHALL be input, DATA_WIDTH bits: multiplicand or dividend (rs).
REQ-007 Port B SHALL be input, DATA_WIDTH bits: multiplier or divisor (rt).
REQ-008 Ports mthi and mtlo SHALL be inputs, 1 bit each: direct write of wdata into HI or LO.
REQ-009 Port wdata SHALL be input, DATA_WIDTH bits: data for mthi/mtlo.
REQ-010 Port busy SHALL be output, 1 bit: operation in progress; the pipeline stalls mfhi/mflo/mult/div while it is high.
REQ-011 Port done SHALL be output, 1 bit: one-cycle pulse, high when the result is valid in HI/LO.
REQ-012 Port hi SHALL be output, DATA_WIDTH bits: HI register (product upper half, or remainder).
REQ-013 Port lo SHALL be output, DATA_WIDTH bits: LO register (product lower half, or quotient).
REQ-014 Port div_by_zero SHALL be output, 1 bit: sticky flag for the last division; set when done is high with B==0, cleared at the next accepted start.

Function
REQ-015 The FSM SHALL have four states, IDLE, RUN, FIX and DONE, with these transitions:
- IDLE/DONE to RUN on start.
- RUN to FIX after exactly DATA_WIDTH RUN cycles.
- FIX to DONE unconditionally.
- DONE to IDLE when start is low.
REQ-016 Operand capture SHALL work as follows:
- A, B and op are captured on the edge that accepts start.
- Later changes to A, B or op have no effect on the running operation.
REQ-017 Latency SHALL be as follows, with start high at cycle 0:
- busy is high in cycles 1 to DATA_WIDTH+1 (RUN, then FIX).
- done is high and busy low in cycle DATA_WIDTH+2.
- HI/LO hold the new result from cycle DATA_WIDTH+2 onward.
REQ-018 HI and LO SHALL keep their previous values until the DONE cycle; intermediate values are never visible on hi/lo.
REQ-019 Multiplication SHALL work as follows:
- Shift-add, one multiplier bit per RUN cycle, on operand magnitudes.
- FIX negates the 2*DATA_WIDTH product when op=MULT and the operand signs differ.
- {hi,lo} equals the full exact product.
REQ-020 Division SHALL work as follows:
- Restoring, one quotient bit per RUN cycle, on magnitudes.
- For op=DIV, FIX sets the quotient sign to sign(A) xor sign(B) and the remainder sign to sign(A).
- Truncation is toward zero; lo = quotient, hi = remainder.
REQ-021 When B==0 on a divide, the unit SHALL still take the full latency and then:
- lo = all ones, hi = captured A, div_by_zero = 1.
- No other state is corrupted.
REQ-022 The signed overflow case (op=DIV, A = most-negative, B = -1) SHALL give lo = most-negative and hi = 0.
REQ-023 A start while busy is high SHALL be ignored; no queuing, and the running operation is unaffected.
REQ-024 A start that is high in the DONE cycle SHALL be accepted; a back-to-back operation proceeds with no idle cycle.
REQ-025 mthi/mtlo SHALL write HI/LO at the next edge only in IDLE or DONE with start low.
REQ-026 mthi/mtlo SHALL be ignored while busy, or when start is high in the same cycle.
REQ-027 mthi and mtlo asserted together SHALL write wdata to both registers.
REQ-028 In the DONE cycle, a mthi/mtlo SHALL take effect on the following edge, after the result has been committed.
REQ-029 done SHALL never be high for two consecutive cycles of the same operation.

Reset
REQ-030 When reset is low at a rising edge, the unit SHALL enter IDLE with hi=0, lo=0, busy=0, done=0, div_by_zero=0 and all internal counters/accumulators at 0.
REQ-031 A reset during RUN or FIX SHALL abort the operation with no done pulse; the captured operands are discarded.
REQ-032 After reset is released, start SHALL be accepted at the first edge where reset is high.

Verification
REQ-033 Unsigned multiply: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high in cycles 1-33.
REQ-034 Signed multiply: MULT A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-035 Signed divide: DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_by_zero=0.
REQ-036 Divide by zero: DIVU A=100, B=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1; a following MULTU 2*3 -> div_by_zero=0, lo=6, hi=0.
REQ-037 Reset mid-operation: MULT started, reset low at cycle 10 -> cycle 11 busy=0, hi=lo=0, and no done pulse ever follows.
REQ-038 Ignore rules and direct writes:
- mtlo with wdata=0x1234 in IDLE -> lo=0x00001234.
- start and mthi while busy -> both ignored; the original result appears at cycle 34.
- Back-to-back: start in the DONE cycle -> second done at cycle 68.
